// File: rtl/traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : traffic_phase_ctrl
// Description : Two-road traffic phase sequencer with pedestrian requests and
//               a flashing-red override, timed by a 1 Hz master tick.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_ctrl #(
   parameter int GREEN_T  = 10,
   parameter int YELLOW_T = 3,
   parameter int ALLRED_T = 1,
   parameter int CNT_W    = 8
) (
   input  logic       clk_50_mhz,
   input  logic       rst_n,
   input  logic       clk_mstr,
   input  logic       ped_req_ns,
   input  logic       ped_req_ew,
   input  logic       flash,
   output logic       timer_enable_n,
   output logic [2:0] ns_rgy,
   output logic [2:0] ew_rgy,
   output logic       ns_walk,
   output logic       ew_walk,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      START = 3'd0,
      NS_G  = 3'd1,
      NS_Y  = 3'd2,
      NS_AR = 3'd3,
      EW_G  = 3'd4,
      EW_Y  = 3'd5,
      EW_AR = 3'd6,
      FLASH = 3'd7
   } state_t;

   // Counter reload values; a zero duration behaves as one tick.
   localparam logic [CNT_W-1:0] G_LD  = CNT_W'((GREEN_T  > 0) ? GREEN_T  - 1 : 0);
   localparam logic [CNT_W-1:0] Y_LD  = CNT_W'((YELLOW_T > 0) ? YELLOW_T - 1 : 0);
   localparam logic [CNT_W-1:0] AR_LD = CNT_W'((ALLRED_T > 0) ? ALLRED_T - 1 : 0);

   logic [1:0]       mstr_sync;
   logic             mstr_prev;
   logic [1:0]       ns_sync;
   logic [1:0]       ew_sync;
   logic [1:0]       flash_sync;
   logic             tick;
   logic             ns_s;
   logic             ew_s;
   logic             flash_s;

   state_t           state;
   state_t           nxt;
   logic [CNT_W-1:0] cnt;
   logic             pend_ns;
   logic             pend_ew;
   logic             flash_bit;

   always_ff @(posedge clk_50_mhz or negedge rst_n) begin
      if (!rst_n) begin
         mstr_sync  <= 2'b00;
         mstr_prev  <= 1'b0;
         ns_sync    <= 2'b00;
         ew_sync    <= 2'b00;
         flash_sync <= 2'b00;
      end else begin
         mstr_sync  <= {mstr_sync[0], clk_mstr};
         mstr_prev  <= mstr_sync[1];
         ns_sync    <= {ns_sync[0], ped_req_ns};
         ew_sync    <= {ew_sync[0], ped_req_ew};
         flash_sync <= {flash_sync[0], flash};
      end
   end

   assign tick    = mstr_sync[1] & ~mstr_prev;
   assign ns_s    = ns_sync[1];
   assign ew_s    = ew_sync[1];
   assign flash_s = flash_sync[1];

   function automatic state_t next_of(input state_t s);
      state_t n;
      case (s)
         START:   n = NS_G;
         NS_G:    n = NS_Y;
         NS_Y:    n = NS_AR;
         NS_AR:   n = EW_G;
         EW_G:    n = EW_Y;
         EW_Y:    n = EW_AR;
         default: n = NS_G;
      endcase
      return n;
   endfunction

   function automatic logic [CNT_W-1:0] load_of(input state_t s);
      logic [CNT_W-1:0] v;
      case (s)
         NS_G, EW_G: v = G_LD;
         NS_Y, EW_Y: v = Y_LD;
         default:    v = AR_LD;
      endcase
      return v;
   endfunction

   // Packed as {ns_rgy, ew_rgy}, each {red, yellow, green}.
   function automatic logic [5:0] lamps_of(input state_t s);
      logic [5:0] v;
      case (s)
         NS_G:    v = 6'b001_100;
         NS_Y:    v = 6'b010_100;
         EW_G:    v = 6'b100_001;
         EW_Y:    v = 6'b100_010;
         default: v = 6'b100_100;
      endcase
      return v;
   endfunction

   assign nxt = next_of(state);

   always_ff @(posedge clk_50_mhz or negedge rst_n) begin
      if (!rst_n) begin
         state          <= START;
         cnt            <= AR_LD;
         pend_ns        <= 1'b0;
         pend_ew        <= 1'b0;
         flash_bit      <= 1'b0;
         ns_rgy         <= 3'b100;
         ew_rgy         <= 3'b100;
         ns_walk        <= 1'b0;
         ew_walk        <= 1'b0;
         phase          <= 3'd0;
         timer_enable_n <= 1'b1;
      end else begin
         timer_enable_n <= 1'b0;
         if (ns_s) pend_ns <= 1'b1;
         if (ew_s) pend_ew <= 1'b1;

         if (flash_s && state != FLASH) begin
            state     <= FLASH;
            phase     <= FLASH;
            flash_bit <= 1'b1;
            ns_rgy    <= 3'b100;
            ew_rgy    <= 3'b100;
            ns_walk   <= 1'b0;
            ew_walk   <= 1'b0;
         end else if (state == FLASH) begin
            if (!flash_s) begin
               state  <= START;
               phase  <= START;
               cnt    <= AR_LD;
               ns_rgy <= 3'b100;
               ew_rgy <= 3'b100;
            end else if (tick) begin
               flash_bit <= ~flash_bit;
               ns_rgy    <= {~flash_bit, 2'b00};
               ew_rgy    <= {~flash_bit, 2'b00};
            end
         end else if (tick) begin
            if (cnt != '0) begin
               cnt <= cnt - 1'b1;
            end else begin
               // Walk lamps are granted only on entry to their own green.
               state            <= nxt;
               phase            <= nxt;
               cnt              <= load_of(nxt);
               {ns_rgy, ew_rgy} <= lamps_of(nxt);
               ns_walk          <= (nxt == NS_G) ? (pend_ns | ns_s) : 1'b0;
               ew_walk          <= (nxt == EW_G) ? (pend_ew | ew_s) : 1'b0;
               if (nxt == NS_G) pend_ns <= 1'b0;
               if (nxt == EW_G) pend_ew <= 1'b0;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_phase_ctrl
// Description : Self-checking bench for traffic_phase_ctrl (two parameter sets).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clk_mstr = 1'b0;
   logic ped_ns = 1'b0;
   logic ped_ew = 1'b0;
   logic flash = 1'b0;

   logic       ten_a, ten_b, nsw_a, nsw_b, eww_a, eww_b;
   logic [2:0] nsr_a, nsr_b, ewr_a, ewr_b, ph_a, ph_b;
   logic [11:0] out_a, out_b;

   assign out_a = {ph_a, nsr_a, ewr_a, nsw_a, eww_a, ten_a};
   assign out_b = {ph_b, nsr_b, ewr_b, nsw_b, eww_b, ten_b};

   always #10 clk = ~clk;

   traffic_phase_ctrl #(.GREEN_T(4), .YELLOW_T(2), .ALLRED_T(1), .CNT_W(8)) u_a (
      .clk_50_mhz(clk), .rst_n(rst_n), .clk_mstr(clk_mstr), .ped_req_ns(ped_ns),
      .ped_req_ew(ped_ew), .flash(flash), .timer_enable_n(ten_a), .ns_rgy(nsr_a),
      .ew_rgy(ewr_a), .ns_walk(nsw_a), .ew_walk(eww_a), .phase(ph_a));

   traffic_phase_ctrl #(.GREEN_T(4), .YELLOW_T(0), .ALLRED_T(1), .CNT_W(8)) u_b (
      .clk_50_mhz(clk), .rst_n(rst_n), .clk_mstr(clk_mstr), .ped_req_ns(ped_ns),
      .ped_req_ew(ped_ew), .flash(flash), .timer_enable_n(ten_b), .ns_rgy(nsr_b),
      .ew_rgy(ewr_b), .ns_walk(nsw_b), .ew_walk(eww_b), .phase(ph_b));

   int total = 0;
   int bad = 0;

   // Reference model: phase number plus ticks remaining in that phase.
   int   cfg_g[2]  = '{4, 4};
   int   cfg_y[2]  = '{2, 0};
   int   cfg_ar[2] = '{1, 1};
   int   m_ph[2];
   int   m_rem[2];
   logic m_fb[2], m_pns[2], m_pew[2], m_nsw[2], m_eww[2], m_ten[2];
   logic [2:0] d_m, d_f, d_n, d_e;

   int   mcnt = 0;
   bit   mstr_on = 1'b0;
   bit   rose = 1'b0;

   typedef struct {
      int         tick;
      logic [2:0] ph_a;
      logic [2:0] ph_b;
   } vec_t;
   vec_t vecs[16];

   function automatic int dur(input int i, input int p);
      int d;
      case (p)
         1, 4:    d = cfg_g[i];
         2, 5:    d = cfg_y[i];
         default: d = cfg_ar[i];
      endcase
      return (d < 1) ? 1 : d;
   endfunction

   function automatic logic [2:0] lamp(input int p, input logic fb, input bit is_ns);
      case (p)
         1:       return is_ns ? 3'b001 : 3'b100;
         2:       return is_ns ? 3'b010 : 3'b100;
         4:       return is_ns ? 3'b100 : 3'b001;
         5:       return is_ns ? 3'b100 : 3'b010;
         7:       return {fb, 2'b00};
         default: return 3'b100;
      endcase
   endfunction

   function automatic logic [11:0] exp_of(input int i);
      return {3'(m_ph[i]), lamp(m_ph[i], m_fb[i], 1'b1), lamp(m_ph[i], m_fb[i], 1'b0),
              m_nsw[i], m_eww[i], m_ten[i]};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_ph[i] = 0; m_rem[i] = dur(i, 0); m_fb[i] = 1'b0;
         m_pns[i] = 1'b0; m_pew[i] = 1'b0; m_nsw[i] = 1'b0; m_eww[i] = 1'b0; m_ten[i] = 1'b1;
      end
      d_m = '0; d_f = '0; d_n = '0; d_e = '0;
   endtask

   task automatic model_edge();
      logic t, f, rn, re;
      if (!rst_n) begin
         model_reset();
      end else begin
         t = d_m[1] & ~d_m[2]; f = d_f[1]; rn = d_n[1]; re = d_e[1];
         for (int i = 0; i < 2; i++) begin
            m_ten[i] = 1'b0;
            if (rn) m_pns[i] = 1'b1;
            if (re) m_pew[i] = 1'b1;
            if (f && m_ph[i] != 7) begin
               m_ph[i] = 7; m_fb[i] = 1'b1; m_nsw[i] = 1'b0; m_eww[i] = 1'b0;
            end else if (m_ph[i] == 7) begin
               if (!f) begin
                  m_ph[i] = 0; m_rem[i] = dur(i, 0);
               end else if (t) begin
                  m_fb[i] = ~m_fb[i];
               end
            end else if (t) begin
               m_rem[i]--;
               if (m_rem[i] == 0) begin
                  m_ph[i]  = (m_ph[i] == 6) ? 1 : m_ph[i] + 1;
                  m_rem[i] = dur(i, m_ph[i]);
                  m_nsw[i] = (m_ph[i] == 1) ? m_pns[i] : 1'b0;
                  m_eww[i] = (m_ph[i] == 4) ? m_pew[i] : 1'b0;
                  if (m_ph[i] == 1) m_pns[i] = 1'b0;
                  if (m_ph[i] == 4) m_pew[i] = 1'b0;
               end
            end
         end
         d_m = {d_m[1:0], clk_mstr}; d_f = {d_f[1:0], flash};
         d_n = {d_n[1:0], ped_ns};   d_e = {d_e[1:0], ped_ew};
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      model_edge();
      check("dut_a_outputs", 32'(out_a), 32'(exp_of(0)));
      check("dut_b_outputs", 32'(out_b), 32'(exp_of(1)));
      rose = 1'b0;
      if (mstr_on) begin
         mcnt     = (mcnt + 1) % 40;
         clk_mstr = (mcnt < 20);
         rose     = (mcnt == 0);
      end
   endtask

   task automatic wait_rise();
      int n;
      n = 0;
      while (!rose && n < 200) begin
         cyc();
         n++;
      end
      if (!rose) check("wait_rise_timeout", 32'(n), 32'd0);
   endtask

   task automatic wait_ph(input logic [2:0] want);
      int n;
      n = 0;
      while (ph_a !== want && n < 3000) begin
         cyc();
         n++;
      end
      if (ph_a !== want) check("wait_phase_timeout", 32'(ph_a), 32'(want));
   endtask

   initial begin
      int ns_left, ew_left, fl_left;
      logic [2:0] prev_a, prev_b;

      vecs = '{
         '{1, 3'd1, 3'd1}, '{2, 3'd1, 3'd1}, '{3, 3'd1, 3'd1}, '{4, 3'd1, 3'd1},
         '{5, 3'd2, 3'd2}, '{6, 3'd2, 3'd3}, '{7, 3'd3, 3'd4}, '{8, 3'd4, 3'd4},
         '{9, 3'd4, 3'd4}, '{10, 3'd4, 3'd4}, '{11, 3'd4, 3'd5}, '{12, 3'd5, 3'd6},
         '{13, 3'd5, 3'd1}, '{14, 3'd6, 3'd1}, '{15, 3'd1, 3'd1}, '{16, 3'd1, 3'd1}};

      model_reset();
      repeat (3) cyc();
      check("rst_ns_rgy", 32'(nsr_a), 32'(3'b100));
      check("rst_ew_rgy", 32'(ewr_a), 32'(3'b100));
      check("rst_phase", 32'(ph_a), 32'd0);
      rst_n = 1'b1;
      check("ten_before_edge", 32'(ten_a), 32'd1);
      cyc();
      check("ten_after_release", 32'(ten_a), 32'd0);

      // Normal cycle: phase just before and just after each tick takes effect.
      mstr_on = 1'b1;
      mcnt = 35;
      prev_a = 3'd0;
      prev_b = 3'd0;
      foreach (vecs[i]) begin
         wait_rise();
         cyc();
         cyc();
         check($sformatf("pre_tick%0d_a", vecs[i].tick), 32'(ph_a), 32'(prev_a));
         check($sformatf("pre_tick%0d_b", vecs[i].tick), 32'(ph_b), 32'(prev_b));
         cyc();
         check($sformatf("tick%0d_a", vecs[i].tick), 32'(ph_a), 32'(vecs[i].ph_a));
         check($sformatf("tick%0d_b", vecs[i].tick), 32'(ph_b), 32'(vecs[i].ph_b));
         prev_a = vecs[i].ph_a;
         prev_b = vecs[i].ph_b;
      end

      // EW request during NS green is served for exactly one EW green.
      ped_ew = 1'b1;
      repeat (5) cyc();
      ped_ew = 1'b0;
      wait_ph(3'd4);
      check("ew_walk_served", 32'(eww_a), 32'd1);
      wait_ph(3'd5);
      check("ew_walk_in_yellow", 32'(eww_a), 32'd0);
      wait_ph(3'd4);
      check("ew_walk_second_green", 32'(eww_a), 32'd0);

      // NS request during NS green waits for the next NS green.
      wait_ph(3'd1);
      repeat (3) cyc();
      ped_ns = 1'b1;
      repeat (5) cyc();
      ped_ns = 1'b0;
      repeat (3) cyc();
      check("ns_walk_own_green", 32'(nsw_a), 32'd0);
      wait_ph(3'd2);
      wait_ph(3'd1);
      check("ns_walk_next_green", 32'(nsw_a), 32'd1);

      // Flash override from EW yellow, with an NS request pending.
      wait_ph(3'd5);
      ped_ns = 1'b1;
      repeat (5) cyc();
      ped_ns = 1'b0;
      flash = 1'b1;
      cyc();
      cyc();
      check("flash_latency_2", 32'(ph_a), 32'd5);
      cyc();
      check("flash_latency_3", 32'(ph_a), 32'd7);
      check("flash_entry_red", 32'({nsr_a, ewr_a}), 32'(6'b100_100));
      wait_rise();
      repeat (3) cyc();
      check("flash_red_tick1", 32'({nsr_a, ewr_a}), 32'(6'b000_000));
      wait_rise();
      repeat (3) cyc();
      check("flash_red_tick2", 32'({nsr_a, ewr_a}), 32'(6'b100_100));
      check("flash_walks", 32'({nsw_a, eww_a}), 32'd0);
      flash = 1'b0;
      repeat (3) cyc();
      check("flash_exit_start", 32'(ph_a), 32'd0);
      wait_ph(3'd1);
      check("pend_ns_after_flash", 32'(nsw_a), 32'd1);

      // Asynchronous reset in the middle of NS green.
      repeat (5) cyc();
      rst_n = 1'b0;
      #1;
      model_reset();
      check("async_rst_a", 32'(out_a), 32'(12'b000_100_100_0_0_1));
      check("async_rst_b", 32'(out_b), 32'(12'b000_100_100_0_0_1));
      cyc();
      cyc();
      rst_n = 1'b1;
      check("ten_held_in_reset", 32'(ten_a), 32'd1);
      cyc();
      check("ten_after_rerelease", 32'(ten_a), 32'd0);

      // Randomised traffic against the reference model.
      ns_left = 0; ew_left = 0; fl_left = 0;
      for (int c = 0; c < 6000; c++) begin
         if (ns_left > 0) ns_left--;
         else if ($urandom_range(0, 79) == 0) ns_left = $urandom_range(1, 6);
         if (ew_left > 0) ew_left--;
         else if ($urandom_range(0, 79) == 0) ew_left = $urandom_range(1, 6);
         if (fl_left > 0) fl_left--;
         else if ($urandom_range(0, 599) == 0) fl_left = $urandom_range(1, 150);
         ped_ns = (ns_left > 0);
         ped_ew = (ew_left > 0);
         flash  = (fl_left > 0);
         rst_n  = ($urandom_range(0, 2499) != 0);
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
